vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter VRAM_BASE, default 16'h8000, giving the first CPU/PPU address that maps to VRAM.
REQ-002 The block SHALL have parameter VRAM_DEPTH, default 8192, giving the VRAM size in bytes; the local address width is $clog2(VRAM_DEPTH).
REQ-003 The block SHALL use one clock, clk_in, with an asynchronous, active-high reset, rst_in.
REQ-004 Ports (name, direction, width, meaning):
- clk_in, in, 1: system clock.
- rst_in, in, 1: asynchronous active-high reset.
- tclk_in, in, 1: one-clk T-cycle strobe; period of at least 4 clk.
- lcd_ena_in, in, 1: LCDC.7.
- ppu_mode_in, in, 2: 0 HBlank, 1 VBlank, 2 OAM scan, 3 Drawing.
- bg_addr_in, in, 16, and bg_addr_valid_in, in, 1: background fetcher request.
- bg_data_out, out, 8, and bg_data_valid_out, out, 1: background response.
- obj_addr_in, in, 16, and obj_addr_valid_in, in, 1: sprite fetcher request.
- obj_data_out, out, 8, and obj_data_valid_out, out, 1: sprite response.
- cpu_addr_in, in, 16; cpu_rd_in, in, 1; cpu_wr_in, in, 1; cpu_wdata_in, in, 8: CPU request.
- cpu_rdata_out, out, 8, and cpu_done_out, out, 1: CPU response.
- vram_addr_out, out, 13; vram_we_out, out, 1; vram_wdata_out, out, 8: VRAM port.
- vram_rdata_in, in, 8: VRAM read data; synchronous with one clk latency.

Function
REQ-005 On each clk with tclk_in high, the block SHALL latch every asserted request into its requester's pending slot (address, plus rd/wr/wdata for the CPU); a new request overwrites an unserved one.
REQ-006 The FSM SHALL have three states, IDLE, ISSUE and CAPTURE.
- IDLE to ISSUE on a tclk_in clk when any slot is pending or is being latched that clk.
- ISSUE to CAPTURE unconditionally.
- CAPTURE to IDLE unconditionally.
REQ-007 In IDLE, on the transition, the block SHALL select a winner, drive vram_addr_out = addr - VRAM_BASE (13 bits), drive vram_we_out/vram_wdata_out for CPU writes, and clear the winner's slot.
REQ-008 In CAPTURE, the block SHALL register vram_rdata_in to the winner's data output and pulse the winner's valid/done output for exactly one clk, 3 clk after the granting tclk.
REQ-009 Arbitration in mode 3 with lcd_ena_in=1 SHALL be OBJ over BG, with one exception: after 2 consecutive OBJ grants while BG is pending, the next grant SHALL go to BG. A saturating 2-bit counter tracks this and is cleared on any BG grant.
REQ-010 The CPU in mode 3 with LCD on SHALL never be granted VRAM.
- Reads SHALL complete with cpu_rdata_out = 8'hFF.
- Writes SHALL be dropped.
- cpu_done_out SHALL pulse 1 clk after the request is latched.
REQ-011 In modes 0–2, or with lcd_ena_in=0, only the CPU SHALL be granted; BG/OBJ slots SHALL be cleared with no response pulse.
REQ-012 A request with an address outside [VRAM_BASE, VRAM_BASE+VRAM_DEPTH) SHALL NOT access VRAM.
- BG/OBJ SHALL pulse data_valid with data 8'hFF and valid low.
- The CPU SHALL receive done with 8'hFF.
- In all such cases the response SHALL come 3 clk after the tclk.
REQ-013 A CPU request pending when the mode changes to 3 SHALL be resolved per REQ-010 on the next IDLE decision.
REQ-014 vram_we_out SHALL be high only in ISSUE, and only for a granted in-range CPU write.
REQ-015 Simultaneous rd and wr SHALL be treated as a write.

Reset
REQ-016 While rst_in is high, asynchronously, the block SHALL set:
- state = IDLE;
- all slots empty and the starvation counter = 0;
- all valid/done outputs = 0;
- all data outputs = 8'h00;
- vram_addr_out = 0, vram_we_out = 0, vram_wdata_out = 0.
REQ-017 Reset asserted mid-transaction SHALL abort it with no response pulse and no write.

Structure
REQ-018 The shared package ppu_pkg SHALL hold the PpuMode enum, the ArbState enum, and the VRAM_BASE/VRAM_END constants.
REQ-019 Each pending slot SHALL be one instance of sub-module vram_req_slot (latch, overwrite, clear, pending flag), instantiated three times.

Verification
REQ-020 Mode 3, BG request 16'h9800 on a tclk, VRAM[0x1800]=8'h3C -> vram_addr_out=0x1800 in ISSUE; bg_data_out=8'h3C with bg_data_valid_out for 1 clk, 3 clk later.
REQ-021 Mode 3, BG and OBJ requested on the same tclk -> OBJ served first, BG in the next slot; with 3 OBJ requests plus BG pending -> BG is the third grant.
REQ-022 Mode 3, CPU read 16'h8000 -> cpu_done_out with 8'hFF after 1 clk, no VRAM access; CPU write -> vram_we_out never asserts.
REQ-023 Mode 0, CPU write 16'h8010=8'hAA then read -> write at local 0x0010; read returns 8'hAA.
REQ-024 BG request 16'h7FFF -> no VRAM access; bg_data_valid_out stays low; bg_data_out=8'hFF.
REQ-025 Reset asserted during ISSUE of a CPU write -> no write, no done pulse, all outputs at reset values.

Source files
------------

// File: rtl/ppu_pkg.sv
// PPU-side shared types and constants for the VRAM arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ppu_pkg;

    // LCD controller mode as reported in STAT[1:0]
    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } PpuMode;

    // Arbiter sequencer: grant, drive the VRAM port, capture the read data
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } ArbState;

    // Which requester owns the access currently in flight
    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_BG   = 2'd1,
        WIN_OBJ  = 2'd2,
        WIN_CPU  = 2'd3
    } arb_winner_e;

    // Default VRAM window: [VRAM_BASE, VRAM_END), VRAM_END is exclusive
    localparam logic [15:0] VRAM_BASE  = 16'h8000;
    localparam int          VRAM_DEPTH = 8192;
    localparam logic [16:0] VRAM_END   = 17'h0A000;

    // OBJ grants in a row (with BG waiting) before BG is forced through
    localparam logic [1:0]  STARVE_LIMIT = 2'd2;

    // CPU pending-slot payload; wr set means write (wins over a simultaneous rd)
    typedef struct packed {
        logic        wr;
        logic [7:0]  wdata;
        logic [15:0] addr;
    } cpu_req_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Request/response and VRAM-port bundle between the PPU/CPU side and the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requests are strobed on tclk and responses are single-clk pulses.
interface vram_arbiter_if;

    logic        tclk_in;
    logic        lcd_ena_in;
    logic [1:0]  ppu_mode_in;

    logic [15:0] bg_addr_in;
    logic        bg_addr_valid_in;
    logic [7:0]  bg_data_out;
    logic        bg_data_valid_out;

    logic [15:0] obj_addr_in;
    logic        obj_addr_valid_in;
    logic [7:0]  obj_data_out;
    logic        obj_data_valid_out;

    logic [15:0] cpu_addr_in;
    logic        cpu_rd_in;
    logic        cpu_wr_in;
    logic [7:0]  cpu_wdata_in;
    logic [7:0]  cpu_rdata_out;
    logic        cpu_done_out;

    logic [12:0] vram_addr_out;
    logic        vram_we_out;
    logic [7:0]  vram_wdata_out;
    logic [7:0]  vram_rdata_in;

    // Arbiter side
    modport slave (
        input  tclk_in, lcd_ena_in, ppu_mode_in,
        input  bg_addr_in, bg_addr_valid_in,
        input  obj_addr_in, obj_addr_valid_in,
        input  cpu_addr_in, cpu_rd_in, cpu_wr_in, cpu_wdata_in,
        input  vram_rdata_in,
        output bg_data_out, bg_data_valid_out,
        output obj_data_out, obj_data_valid_out,
        output cpu_rdata_out, cpu_done_out,
        output vram_addr_out, vram_we_out, vram_wdata_out
    );

    // Requester / memory side
    modport master (
        output tclk_in, lcd_ena_in, ppu_mode_in,
        output bg_addr_in, bg_addr_valid_in,
        output obj_addr_in, obj_addr_valid_in,
        output cpu_addr_in, cpu_rd_in, cpu_wr_in, cpu_wdata_in,
        output vram_rdata_in,
        input  bg_data_out, bg_data_valid_out,
        input  obj_data_out, obj_data_valid_out,
        input  cpu_rdata_out, cpu_done_out,
        input  vram_addr_out, vram_we_out, vram_wdata_out
    );

endinterface

// File: rtl/vram_req_slot.sv
// One-deep pending-request holder: load on ld_i, drop on clr_i, newest request overwrites.
// Latency: pend_o/dat_o show a request in the same clk it is loaded (bypass of the register).
// Backpressure: none; an unserved request is silently replaced by the next one.
module vram_req_slot #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] dat_i,
    output logic         pend_o,
    output logic [W-1:0] dat_o
);

    logic         pend_q;
    logic [W-1:0] dat_q;

    // Effective view includes a request arriving this clk so it can be granted at once
    assign pend_o = pend_q | ld_i;
    assign dat_o  = ld_i ? dat_i : dat_q;

    // Clear beats load: a slot is only cleared when its effective request was just granted
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend_q <= 1'b0;
            dat_q  <= '0;
        end else if (clr_i) begin
            pend_q <= 1'b0;
        end else if (ld_i) begin
            pend_q <= 1'b1;
            dat_q  <= dat_i;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one VRAM port between the BG fetcher, OBJ fetcher and CPU on T-cycle strobes.
// Latency: granted response 3 clk after the tclk; blocked CPU answered 1 clk after latch.
// Backpressure: none; one pending slot per requester, newer requests overwrite older ones.
module vram_arbiter #(
    parameter logic [15:0] VRAM_BASE  = ppu_pkg::VRAM_BASE,
    parameter int          VRAM_DEPTH = ppu_pkg::VRAM_DEPTH
) (
    input logic           clk_in,
    input logic           rst_in,
    vram_arbiter_if.slave bus
);

    import ppu_pkg::*;

    localparam int AW = $clog2(VRAM_DEPTH);
    localparam int LO = int'(VRAM_BASE);
    localparam int HI = LO + VRAM_DEPTH;

    function automatic logic in_range(input logic [15:0] a);
        return (int'(a) >= LO) && (int'(a) < HI);
    endfunction

    PpuMode      mode;
    ArbState     state_q;
    arb_winner_e win_q;
    arb_winner_e win_d;
    logic        win_oor_q;
    logic [1:0]  starve_q;

    logic [12:0] vram_addr_q;
    logic        vram_we_q;
    logic [7:0]  vram_wdata_q;
    logic [7:0]  bg_data_q;
    logic        bg_vld_q;
    logic [7:0]  obj_data_q;
    logic        obj_vld_q;
    logic [7:0]  cpu_rdata_q;
    logic        cpu_done_q;

    logic        bg_ld, obj_ld, cpu_ld;
    logic        bg_clr, obj_clr, cpu_clr;
    logic        bg_pend, obj_pend, cpu_pend;
    logic [15:0] bg_addr, obj_addr;
    cpu_req_t    cpu_new, cpu_req;
    logic [$bits(cpu_req_t)-1:0] cpu_slot_dat;

    logic        decide;
    logic        draw;
    logic        cpu_block;
    logic [15:0] win_addr;
    logic [15:0] win_off;
    logic [7:0]  cap_dat;

    assign mode   = PpuMode'(bus.ppu_mode_in);
    assign draw   = bus.lcd_ena_in && (mode == MODE_DRAW);
    assign bg_ld  = bus.tclk_in && bus.bg_addr_valid_in;
    assign obj_ld = bus.tclk_in && bus.obj_addr_valid_in;
    assign cpu_ld = bus.tclk_in && (bus.cpu_rd_in || bus.cpu_wr_in);

    // Pack the CPU request; wr alone decides direction so rd+wr behaves as a write
    always_comb begin
        cpu_new       = '0;
        cpu_new.wr    = bus.cpu_wr_in;
        cpu_new.wdata = bus.cpu_wdata_in;
        cpu_new.addr  = bus.cpu_addr_in;
    end

    assign cpu_req = cpu_req_t'(cpu_slot_dat);

    vram_req_slot #(.W(16)) u_bg_slot (
        .clk_in (clk_in), .rst_in (rst_in),
        .ld_i   (bg_ld),  .clr_i  (bg_clr), .dat_i (bus.bg_addr_in),
        .pend_o (bg_pend), .dat_o (bg_addr)
    );

    vram_req_slot #(.W(16)) u_obj_slot (
        .clk_in (clk_in), .rst_in (rst_in),
        .ld_i   (obj_ld), .clr_i  (obj_clr), .dat_i (bus.obj_addr_in),
        .pend_o (obj_pend), .dat_o (obj_addr)
    );

    vram_req_slot #(.W($bits(cpu_req_t))) u_cpu_slot (
        .clk_in (clk_in), .rst_in (rst_in),
        .ld_i   (cpu_ld), .clr_i  (cpu_clr), .dat_i (cpu_new),
        .pend_o (cpu_pend), .dat_o (cpu_slot_dat)
    );

    // Decisions happen only in IDLE on a tclk, so every grant is tclk-aligned
    assign decide = (state_q == ST_IDLE) && bus.tclk_in && (bg_pend || obj_pend || cpu_pend);

    // Winner selection: PPU owns VRAM while drawing (OBJ first, BG rescued after two OBJ
    // grants), otherwise only the CPU may access it and stale fetcher requests are dropped
    always_comb begin
        win_d     = WIN_NONE;
        win_addr  = 16'h0000;
        bg_clr    = 1'b0;
        obj_clr   = 1'b0;
        cpu_clr   = 1'b0;
        cpu_block = 1'b0;
        if (decide) begin
            if (draw) begin
                cpu_block = cpu_pend;
                cpu_clr   = cpu_pend;
                if (obj_pend && !(bg_pend && (starve_q >= STARVE_LIMIT))) begin
                    win_d    = WIN_OBJ;
                    win_addr = obj_addr;
                    obj_clr  = 1'b1;
                end else if (bg_pend) begin
                    win_d    = WIN_BG;
                    win_addr = bg_addr;
                    bg_clr   = 1'b1;
                end
            end else begin
                bg_clr  = bg_pend;
                obj_clr = obj_pend;
                if (cpu_pend) begin
                    win_d    = WIN_CPU;
                    win_addr = cpu_req.addr;
                    cpu_clr  = 1'b1;
                end
            end
        end
    end

    assign win_off = win_addr - VRAM_BASE;
    assign cap_dat = win_oor_q ? 8'hFF : bus.vram_rdata_in;

    // Sequencer with registered VRAM port and response outputs; pulses default low each clk
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            win_q        <= WIN_NONE;
            win_oor_q    <= 1'b0;
            starve_q     <= 2'd0;
            vram_addr_q  <= 13'h0000;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= 8'h00;
            bg_data_q    <= 8'h00;
            bg_vld_q     <= 1'b0;
            obj_data_q   <= 8'h00;
            obj_vld_q    <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            cpu_done_q   <= 1'b0;
        end else begin
            bg_vld_q   <= 1'b0;
            obj_vld_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            // CPU locked out of VRAM during drawing: answer immediately, never touch memory
            if (cpu_block) begin
                cpu_done_q  <= 1'b1;
                cpu_rdata_q <= 8'hFF;
            end
            case (state_q)
                ST_IDLE: begin
                    if (decide) begin
                        state_q   <= ST_ISSUE;
                        win_q     <= win_d;
                        win_oor_q <= !in_range(win_addr);
                        if ((win_d != WIN_NONE) && in_range(win_addr)) begin
                            vram_addr_q <= 13'(win_off[AW-1:0]);
                            if ((win_d == WIN_CPU) && cpu_req.wr) begin
                                vram_we_q    <= 1'b1;
                                vram_wdata_q <= cpu_req.wdata;
                            end
                        end
                        if (win_d == WIN_BG) begin
                            starve_q <= 2'd0;
                        end else if ((win_d == WIN_OBJ) && bg_pend && (starve_q != 2'd3)) begin
                            starve_q <= starve_q + 2'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    vram_we_q <= 1'b0;
                    state_q   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                    case (win_q)
                        WIN_BG: begin
                            bg_data_q <= cap_dat;
                            bg_vld_q  <= !win_oor_q;
                        end
                        WIN_OBJ: begin
                            obj_data_q <= cap_dat;
                            obj_vld_q  <= !win_oor_q;
                        end
                        WIN_CPU: begin
                            cpu_rdata_q <= cap_dat;
                            cpu_done_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.vram_addr_out      = vram_addr_q;
    assign bus.vram_we_out        = vram_we_q;
    assign bus.vram_wdata_out     = vram_wdata_q;
    assign bus.bg_data_out        = bg_data_q;
    assign bus.bg_data_valid_out  = bg_vld_q;
    assign bus.obj_data_out       = obj_data_q;
    assign bus.obj_data_valid_out = obj_vld_q;
    assign bus.cpu_rdata_out      = cpu_rdata_q;
    assign bus.cpu_done_out       = cpu_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected responses queued at stimulus, popped on pulses.
// Latency: responses checked against the exact clk they are due.
// Backpressure: n/a.
module tb_vram_arbiter;

    localparam int WHO_BG  = 0;
    localparam int WHO_OBJ = 1;
    localparam int WHO_CPU = 2;

    typedef struct {
        logic [7:0] dat;
        bit         chk_dat;
        int         due;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    vram_arbiter_if bus();

    vram_arbiter #(.VRAM_BASE(16'h8000), .VRAM_DEPTH(8192)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int   cyc = 0;
    int   we_cnt = 0;
    int   chk_cnt = 0;
    int   err_cnt = 0;
    exp_t bg_q[$];
    exp_t obj_q[$];
    exp_t cpu_q[$];
    exp_t e;
    logic       mem_ready = 1'b0;
    logic [7:0] mem [0:8191];

    function automatic logic [7:0] init_val(input int i);
        if (i == 'h1800) return 8'h3C;
        return 8'(i) ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Synchronous VRAM model, one clk read latency; filled once during the first reset
    always @(posedge clk_in) begin
        if (!mem_ready) begin
            if (rst_in) begin
                for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
                mem_ready <= 1'b1;
            end
        end else if (bus.vram_we_out) begin
            mem[bus.vram_addr_out] <= bus.vram_wdata_out;
        end
        bus.vram_rdata_in <= mem[bus.vram_addr_out];
    end

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (bus.vram_we_out) we_cnt <= we_cnt + 1;
    end

    // Response monitor: every pulse must match the head of its queue, data and clk
    always @(negedge clk_in) begin
        if (bus.bg_data_valid_out) begin
            if (bg_q.size() == 0) chk("bg_vld_unexpected", 32'(bus.bg_data_valid_out), 32'd0);
            else begin
                e = bg_q.pop_front();
                chk("bg_dat", 32'(bus.bg_data_out), 32'(e.dat));
                chk("bg_cyc", cyc, e.due);
            end
        end
        if (bus.obj_data_valid_out) begin
            if (obj_q.size() == 0) chk("obj_vld_unexpected", 32'(bus.obj_data_valid_out), 32'd0);
            else begin
                e = obj_q.pop_front();
                chk("obj_dat", 32'(bus.obj_data_out), 32'(e.dat));
                chk("obj_cyc", cyc, e.due);
            end
        end
        if (bus.cpu_done_out) begin
            if (cpu_q.size() == 0) chk("cpu_done_unexpected", 32'(bus.cpu_done_out), 32'd0);
            else begin
                e = cpu_q.pop_front();
                if (e.chk_dat) chk("cpu_rdata", 32'(bus.cpu_rdata_out), 32'(e.dat));
                chk("cpu_cyc", cyc, e.due);
            end
        end
    end

    task automatic push(input int who, input logic [7:0] d, input bit cd, input int due);
        exp_t x;
        x.dat = d; x.chk_dat = cd; x.due = due;
        if (who == WHO_BG) bg_q.push_back(x);
        else if (who == WHO_OBJ) obj_q.push_back(x);
        else cpu_q.push_back(x);
    endtask

    // Raise tclk with the given requests; c0 is the cyc value right after the granting edge
    task automatic drive(input logic bgv, input logic [15:0] bga,
                         input logic objv, input logic [15:0] obja,
                         input logic rd, input logic wr, input logic [15:0] ca,
                         input logic [7:0] wd, output int c0);
        @(negedge clk_in);
        bus.tclk_in           = 1'b1;
        bus.bg_addr_valid_in  = bgv;
        bus.bg_addr_in        = bga;
        bus.obj_addr_valid_in = objv;
        bus.obj_addr_in       = obja;
        bus.cpu_rd_in         = rd;
        bus.cpu_wr_in         = wr;
        bus.cpu_addr_in       = ca;
        bus.cpu_wdata_in      = wd;
        c0 = cyc + 1;
    endtask

    task automatic release_tclk();
        @(negedge clk_in);
        bus.tclk_in           = 1'b0;
        bus.bg_addr_valid_in  = 1'b0;
        bus.obj_addr_valid_in = 1'b0;
        bus.cpu_rd_in         = 1'b0;
        bus.cpu_wr_in         = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_bg_dat"},   32'(bus.bg_data_out),        32'h00);
        chk({p, "_bg_vld"},   32'(bus.bg_data_valid_out),  32'h0);
        chk({p, "_obj_dat"},  32'(bus.obj_data_out),       32'h00);
        chk({p, "_obj_vld"},  32'(bus.obj_data_valid_out), 32'h0);
        chk({p, "_cpu_dat"},  32'(bus.cpu_rdata_out),      32'h00);
        chk({p, "_cpu_done"}, 32'(bus.cpu_done_out),       32'h0);
        chk({p, "_v_addr"},   32'(bus.vram_addr_out),      32'h0);
        chk({p, "_v_we"},     32'(bus.vram_we_out),        32'h0);
        chk({p, "_v_wdata"},  32'(bus.vram_wdata_out),     32'h00);
    endtask

    initial begin
        int c0;
        int wc;
        logic [12:0] a_save;

        bus.tclk_in = 1'b0; bus.lcd_ena_in = 1'b1; bus.ppu_mode_in = 2'd3;
        bus.bg_addr_in = 16'h0; bus.bg_addr_valid_in = 1'b0;
        bus.obj_addr_in = 16'h0; bus.obj_addr_valid_in = 1'b0;
        bus.cpu_addr_in = 16'h0; bus.cpu_rd_in = 1'b0; bus.cpu_wr_in = 1'b0;
        bus.cpu_wdata_in = 8'h00;
        rst_in = 1'b1;
        gap(3);
        chk_reset_vals("rst");
        rst_in = 1'b0;
        gap(2);

        // Drawing, single BG fetch from tile map
        drive(1, 16'h9800, 0, 16'h0, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_BG, 8'h3C, 1, c0 + 2);
        release_tclk();
        chk("bg_issue_addr", 32'(bus.vram_addr_out), 32'h1800);
        chk("bg_issue_we", 32'(bus.vram_we_out), 32'h0);
        gap(4);

        // BG and OBJ together: OBJ first, BG on the next tclk
        drive(1, 16'h9801, 1, 16'h8123, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_OBJ, init_val('h123), 1, c0 + 2);
        release_tclk(); gap(4);
        drive(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_BG, init_val('h1801), 1, c0 + 2);
        release_tclk(); gap(4);

        // Three OBJ requests with BG waiting: BG forced through as the third grant
        drive(1, 16'h9900, 1, 16'h8200, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_OBJ, init_val('h200), 1, c0 + 2);
        release_tclk(); gap(4);
        drive(0, 16'h0, 1, 16'h8201, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_OBJ, init_val('h201), 1, c0 + 2);
        release_tclk(); gap(4);
        drive(0, 16'h0, 1, 16'h8202, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_BG, init_val('h1900), 1, c0 + 2);
        release_tclk(); gap(4);
        drive(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 8'h00, c0);
        push(WHO_OBJ, init_val('h202), 1, c0 + 2);
        release_tclk(); gap(4);

        // CPU locked out while drawing: read answers FF next clk, write is dropped
        a_save = bus.vram_addr_out;
        wc = we_cnt;
        drive(0, 16'h0, 0, 16'h0, 1, 0, 16'h8000, 8'h00, c0);
        push(WHO_CPU, 8'hFF, 1, c0);
        release_tclk();
        gap(1);
        chk("cpu_blk_rd_addr", 32'(bus.vram_addr_out), 32'(a_save));
        gap(3);
        drive(0, 16'h0, 0, 16'h0, 0, 1, 16'h8005, 8'h77, c0);
        push(WHO_CPU, 8'hFF, 1, c0);
        release_tclk(); gap(4);
        chk("cpu_blk_wr_we", we_cnt, wc);
        chk("cpu_blk_wr_mem", 32'(mem[5]), 32'(init_val(5)));

        // HBlank: CPU write then read back (rd+wr together counts as a write)
        bus.ppu_mode_in = 2'd0;
        drive(0, 16'h0, 0, 16'h0, 1, 1, 16'h8010, 8'hAA, c0);
        push(WHO_CPU, 8'h00, 0, c0 + 2);
        release_tclk();
        chk("cpu_wr_addr", 32'(bus.vram_addr_out), 32'h0010);
        chk("cpu_wr_we", 32'(bus.vram_we_out), 32'h1);
        chk("cpu_wr_wdata", 32'(bus.vram_wdata_out), 32'hAA);
        gap(1);
        chk("cpu_wr_we_drop", 32'(bus.vram_we_out), 32'h0);
        gap(3);
        chk("cpu_wr_mem", 32'(mem['h10]), 32'hAA);
        drive(0, 16'h0, 0, 16'h0, 1, 0, 16'h8010, 8'h00, c0);
        push(WHO_CPU, 8'hAA, 1, c0 + 2);
        release_tclk(); gap(4);

        // Fetcher requests outside drawing vanish; an empty tclk later must stay silent
        drive(1, 16'h9800, 1, 16'h8100, 0, 0, 16'h0, 8'h00, c0);
        release_tclk(); gap(4);
        bus.ppu_mode_in = 2'd3;
        drive(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 8'h00, c0);
        release_tclk(); gap(4);

        // Out-of-range BG: no VRAM access, data FF, valid stays low
        a_save = bus.vram_addr_out;
        wc = we_cnt;
        drive(1, 16'h7FFF, 0, 16'h0, 0, 0, 16'h0, 8'h00, c0);
        release_tclk(); gap(4);
        chk("bg_oor_dat", 32'(bus.bg_data_out), 32'hFF);
        chk("bg_oor_addr", 32'(bus.vram_addr_out), 32'(a_save));
        chk("bg_oor_we", we_cnt, wc);

        // Out-of-range CPU read in HBlank: done with FF, 3 clk after tclk
        bus.ppu_mode_in = 2'd0;
        drive(0, 16'h0, 0, 16'h0, 1, 0, 16'h7000, 8'h00, c0);
        push(WHO_CPU, 8'hFF, 1, c0 + 2);
        release_tclk(); gap(4);

        // LCD off in mode 3: CPU owns VRAM, BG request dropped
        bus.ppu_mode_in = 2'd3;
        bus.lcd_ena_in  = 1'b0;
        drive(1, 16'h9800, 0, 16'h0, 1, 0, 16'h8010, 8'h00, c0);
        push(WHO_CPU, 8'hAA, 1, c0 + 2);
        release_tclk(); gap(4);

        // Reset during ISSUE of a CPU write: no write, no done, outputs back to reset values
        bus.lcd_ena_in  = 1'b1;
        bus.ppu_mode_in = 2'd0;
        wc = we_cnt;
        drive(0, 16'h0, 0, 16'h0, 0, 1, 16'h8020, 8'h55, c0);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        release_tclk();
        chk_reset_vals("mid_rst");
        gap(3);
        chk("mid_rst_mem", 32'(mem['h20]), 32'(init_val('h20)));
        chk("mid_rst_we", we_cnt, wc);
        rst_in = 1'b0;
        gap(2);

        // Recovery after reset
        drive(0, 16'h0, 0, 16'h0, 1, 0, 16'h8010, 8'h00, c0);
        push(WHO_CPU, 8'hAA, 1, c0 + 2);
        release_tclk(); gap(4);

        chk("bg_q_left", bg_q.size(), 0);
        chk("obj_q_left", obj_q.size(), 0);
        chk("cpu_q_left", cpu_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
